// File: rtl/mem_stage_pkg.sv
// Shared EX/MEM definitions: memory opcodes, funct3 width codes, MEM FSM states
// and small decode helpers used by the memory stage and its lane aligner.
package mem_stage_pkg;

    localparam logic [6:0] LOAD_OP_DEF  = 7'b0000011;
    localparam logic [6:0] STORE_OP_DEF = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        WIDTH_B = 2'd0,
        WIDTH_H = 2'd1,
        WIDTH_W = 2'd2
    } width_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Reserved encodings (011/110/111) fall back to a full word access.
    function automatic width_e width_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return WIDTH_B;
            F3_H, F3_HU: return WIDTH_H;
            F3_W:        return WIDTH_W;
            default:     return WIDTH_W;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (width_of(f3))
            WIDTH_H: return lo[0];
            WIDTH_W: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the data-memory port: store byte enables and replicated
// write data, plus load byte/half selection with sign or zero extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_lo_i,
    input  logic [2:0]  st_funct3_i,
    input  logic        st_is_load_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_lo_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  rd_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        ld_uns;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_bytes[gi] = ld_rdata_i[8*gi +: 8];
        end
    endgenerate

    // Replicating the data across lanes lets the be mask alone pick the target bytes.
    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        if (!st_is_load_i) begin
            case (width_of(st_funct3_i))
                WIDTH_B: begin
                    st_be_o    = 4'b0001 << st_lo_i;
                    st_wdata_o = {4{st_data_i[7:0]}};
                end
                WIDTH_H: begin
                    st_be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
                    st_wdata_o = {2{st_data_i[15:0]}};
                end
                default: begin
                    st_be_o    = 4'b1111;
                    st_wdata_o = st_data_i;
                end
            endcase
        end
    end

    always_comb begin
        sel_byte  = rd_bytes[ld_lo_i];
        sel_half  = ld_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_uns    = is_unsigned(ld_funct3_i);
        ld_data_o = ld_rdata_i;
        case (width_of(ld_funct3_i))
            WIDTH_B: ld_data_o = ld_uns ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            WIDTH_H: ld_data_o = ld_uns ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: accepts EX results, runs loads/stores over a req/ack port
// with a timeout, and registers one result per instruction toward write-back.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [6:0] LOAD_OP        = LOAD_OP_DEF,
    parameter logic [6:0] STORE_OP       = STORE_OP_DEF,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] c,
    input  logic [31:0] data2,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, we_q;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        be_q;
    logic [1:0]        lo_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic              wb_valid_q, wb_rw_q, misalign_q, bus_err_q;
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_data_q;

    logic        is_load, is_store, is_mem, misalign, timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign is_load  = (opcode == LOAD_OP);
    assign is_store = (opcode == STORE_OP);
    assign is_mem   = is_load || is_store;
    assign misalign = is_misaligned(funct3, c[1:0]);
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign timeout  = (cnt_q == CNT_LAST);

    lsu_align u_align (
        .st_lo_i      (c[1:0]),
        .st_funct3_i  (funct3),
        .st_is_load_i (is_load),
        .st_data_i    (data2),
        .st_be_o      (st_be),
        .st_wdata_o   (st_wdata),
        .ld_lo_i      (lo_q),
        .ld_funct3_i  (f3_q),
        .ld_rdata_i   (dmem_rdata),
        .ld_data_o    (ld_data)
    );

    // Stall drops in the ack cycle so EX advances exactly as the access retires.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            if (state_q == ST_IDLE)
                mem_stall = in_valid && is_mem && !misalign;
            else
                mem_stall = !dmem_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd;
                            wb_rw_q    <= reg_write;
                            wb_data_q  <= c;
                        end else if (misalign) begin
                            wb_valid_q <= 1'b1;
                            misalign_q <= 1'b1;
                            wb_rd_q    <= rd;
                            wb_rw_q    <= 1'b0;
                            wb_data_q  <= c;
                        end else begin
                            state_q <= ST_ACCESS;
                            cnt_q   <= '0;
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= {c[31:2], 2'b00};
                            be_q    <= st_be;
                            wdata_q <= st_wdata;
                            lo_q    <= c[1:0];
                            f3_q    <= funct3;
                            rd_q    <= rd;
                            rw_q    <= reg_write && is_load;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_d;
                    if (dmem_ack) begin
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_rw_q    <= rw_q;
                        wb_data_q  <= we_q ? 32'b0 : ld_data;
                    end else if (timeout) begin
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        bus_err_q  <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_rw_q    <= 1'b0;
                        wb_data_q  <= 32'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign exc_misalign = misalign_q;
    assign exc_bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized loads, stores
// and ALU ops against an arithmetic model of RV32I lane and extension rules.
module tb_mem_stage;

    localparam int         T        = 16;
    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;
    localparam logic [6:0] ALU_OP   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] c = '0;
    logic [31:0] data2 = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_write, exc_misalign, exc_bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
        .c(c), .data2(data2), .rd(rd), .reg_write(reg_write), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Access size in bytes from funct3; alignment, lanes and extension follow arithmetically.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
            input logic [31:0] a, input logic [31:0] d2, input logic [31:0] rdata,
            output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld, output bit mis);
        int sz;
        int off;
        logic [31:0] v;
        off = int'(a % 4);
        sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        mis = (off % sz) != 0;
        if (op == LOAD_OP) be = 4'hF;
        else be = 4'(((1 << sz) - 1) << off);
        wd = (sz == 1) ? d2[7:0] * 32'h01010101 : (sz == 2) ? d2[15:0] * 32'h00010001 : d2;
        v = rdata >> (8 * off);
        if (sz == 1) begin
            ld = v & 32'hFF;
            if (f3 == 3'd0 && ld[7]) ld = ld | 32'hFFFFFF00;
        end else if (sz == 2) begin
            ld = v & 32'hFFFF;
            if (f3 == 3'd1 && ld[15]) ld = ld | 32'hFFFF0000;
        end else begin
            ld = rdata;
        end
    endfunction

    // ack_at: ACCESS cycle (1-based) that sees dmem_ack; 0 means never.
    task automatic run_mem(input string tag, input logic [6:0] op, input logic [2:0] f3,
            input logic [31:0] addr, input logic [31:0] d2, input logic [4:0] r, input logic rw,
            input int ack_at, input logic [31:0] rdata);
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld;
        bit          e_mis, acked, is_st;
        logic        e_rw;
        is_st = (op == STORE_OP);
        model(op, f3, addr, d2, rdata, e_be, e_wd, e_ld, e_mis);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; funct3 = f3; c = addr; data2 = d2; rd = r; reg_write = rw;
        #1;
        checks++;
        if (mem_stall !== logic'(!e_mis) || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: stall=%b req=%b required stall=%b req=0", tag, mem_stall, dmem_req, !e_mis);
        end
        if (e_mis) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({wb_valid, exc_misalign, exc_bus_err, wb_reg_write, dmem_req} !== 5'b11000 || wb_rd !== r) begin
                failures++;
                $display("FAIL %s misalign: valid/mis/bus/rw/req=%b rd=%0d required 11000 rd=%0d", tag,
                         {wb_valid, exc_misalign, exc_bus_err, wb_reg_write, dmem_req}, wb_rd, r);
            end
            $display("txn %s addr=%h misaligned", tag, addr);
            return;
        end
        acked = 0;
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== logic'(is_st) || dmem_addr !== {addr[31:2], 2'b00} ||
                dmem_be !== e_be || wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s access%0d: req=%b we=%b addr=%h be=%b wbv=%b required 1 %b %h %b 0", tag, k,
                         dmem_req, dmem_we, dmem_addr, dmem_be, wb_valid, is_st, {addr[31:2], 2'b00}, e_be);
            end
            if (is_st) begin
                checks++;
                if (dmem_wdata !== e_wd) begin
                    failures++;
                    $display("FAIL %s wdata: got %h required %h", tag, dmem_wdata, e_wd);
                end
            end
            dmem_ack   = (k == ack_at);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            // EX-side noise while in ACCESS must not be picked up.
            opcode = ALU_OP; c = $urandom; rd = 5'($urandom);
            #1;
            checks++;
            if (mem_stall !== !dmem_ack) begin
                failures++;
                $display("FAIL %s stall%0d: got %b required %b", tag, k, mem_stall, !dmem_ack);
            end
            if (dmem_ack) begin
                acked = 1;
                break;
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0; in_valid = 1'b0;
        e_rw = acked && !is_st && rw;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== r || exc_misalign !== 1'b0 ||
            exc_bus_err !== logic'(!acked) || wb_reg_write !== e_rw) begin
            failures++;
            $display("FAIL %s result: req=%b v=%b rd=%0d mis=%b bus=%b rw=%b required 0 1 %0d 0 %b %b", tag,
                     dmem_req, wb_valid, wb_rd, exc_misalign, exc_bus_err, wb_reg_write, r, !acked, e_rw);
        end
        if (acked && !is_st) begin
            checks++;
            if (wb_data !== e_ld) begin
                failures++;
                $display("FAIL %s load data: got %h required %h", tag, wb_data, e_ld);
            end
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse end: valid=%b req=%b required 0 0", tag, wb_valid, dmem_req);
        end
        $display("txn %s op=%b f3=%b addr=%h ack_at=%0d be=%b", tag, op, f3, addr, ack_at, e_be);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] val, input logic [4:0] r, input logic rw);
        @(negedge clk);
        in_valid = 1'b1; opcode = ALU_OP; funct3 = 3'($urandom); c = val; rd = r; reg_write = rw;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL %s stall: got %b required 0", tag, mem_stall);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== val || wb_rd !== r || wb_reg_write !== rw ||
            {exc_misalign, exc_bus_err, dmem_req} !== 3'b000) begin
            failures++;
            $display("FAIL %s wb: v=%b data=%h rd=%0d rw=%b exc/req=%b required 1 %h %0d %b 000", tag,
                     wb_valid, wb_data, wb_rd, wb_reg_write, {exc_misalign, exc_bus_err, dmem_req}, val, r, rw);
        end
        $display("txn %s c=%h rd=%0d", tag, val, r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd,
             wb_reg_write, wb_data, exc_misalign, exc_bus_err} !== '0) begin
            failures++;
            $display("FAIL reset outputs: req=%b wbv=%b wb_data=%h addr=%h required all zero",
                     dmem_req, wb_valid, wb_data, dmem_addr);
        end
        rst = 1'b0;
        $display("txn reset");
    endtask

    task automatic test_store();
        run_mem("sw", STORE_OP, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 2, 32'h0);
        run_mem("sb", STORE_OP, 3'b000, 32'h103, 32'h000000AB, 5'd0, 1'b0, 1, 32'h0);
        run_mem("sh_hi", STORE_OP, 3'b001, 32'h202, 32'h1234CAFE, 5'd0, 1'b0, 3, 32'h0);
    endtask

    task automatic test_load();
        run_mem("lb", LOAD_OP, 3'b000, 32'h102, 32'h0, 5'd7, 1'b1, 1, 32'h80FF1234);
        run_mem("lbu", LOAD_OP, 3'b100, 32'h102, 32'h0, 5'd8, 1'b1, 2, 32'h80FF1234);
        run_mem("lhu", LOAD_OP, 3'b101, 32'h102, 32'h0, 5'd9, 1'b1, 1, 32'h80001234);
        run_mem("lh", LOAD_OP, 3'b001, 32'h102, 32'h0, 5'd10, 1'b1, 1, 32'h80001234);
        run_mem("lw_f3_111", LOAD_OP, 3'b111, 32'h300, 32'h0, 5'd11, 1'b1, 1, 32'h13579BDF);
    endtask

    task automatic test_misalign();
        run_mem("lh_mis", LOAD_OP, 3'b001, 32'h101, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        run_mem("sw_mis", STORE_OP, 3'b010, 32'h102, 32'h11223344, 5'd0, 1'b0, 1, 32'h0);
        run_mem("lw_f3_110_mis", LOAD_OP, 3'b110, 32'h301, 32'h0, 5'd6, 1'b1, 1, 32'h0);
    endtask

    task automatic test_timeout();
        run_mem("lw_timeout", LOAD_OP, 3'b010, 32'h400, 32'h0, 5'd12, 1'b1, 0, 32'h0);
        run_mem("lw_ack_last", LOAD_OP, 3'b010, 32'h404, 32'h0, 5'd13, 1'b1, T, 32'hA5A5_5A5A);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [6];
        logic [4:0]  rds [6];
        run_alu("add", 32'h55, 5'd5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            vals[i] = $urandom;
            rds[i]  = 5'($urandom);
        end
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_data !== vals[i-1] || wb_rd !== rds[i-1]) begin
                    failures++;
                    $display("FAIL b2b%0d: v=%b data=%h rd=%0d required 1 %h %0d", i - 1, wb_valid,
                             wb_data, wb_rd, vals[i-1], rds[i-1]);
                end
            end
            if (i < 6) begin
                in_valid = 1'b1; opcode = ALU_OP; c = vals[i]; rd = rds[i]; reg_write = 1'b1;
                #1;
                checks++;
                if (mem_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b stall%0d: got %b required 0", i, mem_stall);
                end
                $display("txn b2b%0d c=%h rd=%0d", i, vals[i], rds[i]);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        in_valid = 1'b1; opcode = LOAD_OP; funct3 = 3'b010; c = 32'h500; rd = 5'd3; reg_write = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd,
             wb_reg_write, wb_data, exc_misalign, exc_bus_err} !== '0) begin
            failures++;
            $display("FAIL reset mid-access: req=%b addr=%h be=%b wbv=%b required all zero",
                     dmem_req, dmem_addr, dmem_be, wb_valid);
        end
        rst = 1'b0;
        repeat (T + 2) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
                failures++;
                $display("FAIL after reset idle: valid=%b req=%b required 0 0", wb_valid, dmem_req);
            end
        end
        $display("txn reset_mid_access");
        run_mem("lw_after_rst", LOAD_OP, 3'b010, 32'h504, 32'h0, 5'd14, 1'b1, 1, 32'hCAFEF00D);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        int kind;
        int ack_at;
        for (int i = 0; i < 60; i++) begin
            kind   = $urandom_range(0, 2);
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            if (kind == 0) begin
                f3 = 3'($urandom);
                run_mem("rnd_ld", LOAD_OP, f3, $urandom, 32'h0, 5'($urandom), 1'($urandom), ack_at, $urandom);
            end else if (kind == 1) begin
                f3 = 3'($urandom_range(0, 2));
                run_mem("rnd_st", STORE_OP, f3, $urandom, $urandom, 5'($urandom), 1'($urandom), ack_at, 32'h0);
            end else begin
                run_alu("rnd_alu", $urandom, 5'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
